pc_register_pair: RTL

- Holds the 16-bit program counter as two 8-bit registers, PCL and PCH.
- Each cycle it selects the PC source: hold, or load from the ADL/ADH address buses. It increments the selected value with carry from PCL into PCH.
- It also performs the one-cycle PCH correction needed when a relative branch crosses a page.
- It is the registered stage around the PC increment logic. Its outputs drive the address bus muxes and the data-bus PC drivers.

---
 rtl/pc_register_pair.sv | 103 ++++++++++
 1 files changed

// File: rtl/pc_register_pair.sv
// Program counter held as two 8-bit halves (PCL/PCH).
// Each IDLE cycle selects hold or bus load per half, optionally increments the
// 16-bit value with carry from PCL into PCH, and can schedule a one-cycle PCH
// correction (FIX) for a relative branch that crossed a page boundary.
// All outputs come straight from registers.
module pc_register_pair #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] IN_ADL,
    input  logic [7:0] IN_ADH,
    input  logic       sig_PCL_LOAD,
    input  logic       sig_PCH_LOAD,
    input  logic       sig_INC,
    input  logic       sig_BR_FIX_UP,
    input  logic       sig_BR_FIX_DN,
    output logic [7:0] OUT_PCL,
    output logic [7:0] OUT_PCH,
    output logic       OUT_FIX_BUSY,
    output logic       OUT_WRAP
);

    typedef enum logic {
        IDLE = 1'b0,
        FIX  = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [7:0] pcl, pch;
    logic [7:0] pcl_next, pch_next;
    logic       fix_dn, fix_dn_next;
    logic       wrap, wrap_next;

    // Source selection and increment are only meaningful in IDLE.
    logic [7:0] pcl_src, pch_src;
    logic [8:0] pcl_sum;
    logic       fix_req;

    // Load muxes, 9-bit PCL increment and the page-fix request decode.
    always_comb begin
        pcl_src = sig_PCL_LOAD ? IN_ADL : pcl;
        pch_src = sig_PCH_LOAD ? IN_ADH : pch;
        pcl_sum = {1'b0, pcl_src} + 9'd1;
        // Both directions at once is contradictory and is dropped.
        fix_req = sig_BR_FIX_UP ^ sig_BR_FIX_DN;
    end

    // Next-state and next-PC logic; FIX ignores every control input.
    always_comb begin
        state_next  = state;
        pcl_next    = pcl;
        pch_next    = pch;
        fix_dn_next = fix_dn;
        wrap_next   = 1'b0;
        case (state)
            IDLE: begin
                if (sig_INC) begin
                    pcl_next  = pcl_sum[7:0];
                    pch_next  = pch_src + {7'd0, pcl_sum[8]};
                    wrap_next = (pcl_src == 8'hFF) && (pch_src == 8'hFF);
                end else begin
                    pcl_next = pcl_src;
                    pch_next = pch_src;
                end
                if (fix_req) begin
                    state_next  = FIX;
                    fix_dn_next = sig_BR_FIX_DN;
                end
            end
            FIX: begin
                // Page wrap of PCH here is a branch artefact, not a PC wrap,
                // so OUT_WRAP stays low.
                pch_next   = fix_dn ? (pch - 8'd1) : (pch + 8'd1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and PC registers; reset wins over everything, including a pending fix.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            pcl    <= RESET_PC[7:0];
            pch    <= RESET_PC[15:8];
            fix_dn <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_next;
            pcl    <= pcl_next;
            pch    <= pch_next;
            fix_dn <= fix_dn_next;
            wrap   <= wrap_next;
        end
    end

    assign OUT_PCL      = pcl;
    assign OUT_PCH      = pch;
    assign OUT_FIX_BUSY = (state == FIX);
    assign OUT_WRAP     = wrap;

endmodule
